// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encodings, data width and
// the parity helper used when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_STOP    = 3'd3;
    localparam logic [2:0] ST_CLEANUP = 3'd4;
    localparam logic [2:0] ST_PARITY  = 3'd5;

    // Expected parity bit for a data word; odd = 1 inverts the even result.
    function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Generic two-flop synchroniser for one asynchronous input; RESET_VAL sets
// the value both stages take during reset.
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with centre-of-bit sampling, valid and framing-error strobes.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY_ODD   = 0
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_Serial,
    output logic              o_Rx_DV,
    output logic [DATA_W-1:0] o_Rx_Byte,
    output logic              o_Rx_Active,
    output logic              o_Rx_Frame_Err,
    output logic              o_Rx_Parity_Err
);

    localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] CNT_HALF = 8'((CLKS_PER_BIT - 1) / 2);

    logic              rx_sync;
    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic              dv_q, dv_d;
    logic              active_q, active_d;
    logic              ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;
`endif

    uart_sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_i(i_Clock),
        .rst_i(i_Reset),
        .d_i  (i_Rx_Serial),
        .q_o  (rx_sync)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        active_d = active_q;
        dv_d     = 1'b0;
        ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
        perr_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                idx_d = 3'd0;
                if (!rx_sync) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = 8'd0;
                    // A line back high at mid start bit was only a glitch.
                    if (!rx_sync) begin
                        active_d = 1'b1;
                        state_d  = ST_DATA;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = 8'd0;
                    shift_d[idx_q] = rx_sync;
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    par_d   = rx_sync;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    ferr_d  = !rx_sync;
                    state_d = ST_CLEANUP;
`ifdef UART_RX_PARITY_EN
                    perr_d  = (par_q != calc_parity(shift_q, PARITY_ODD != 0));
                    if (rx_sync && !perr_d) begin
`else
                    if (rx_sync) begin
`endif
                        dv_d   = 1'b1;
                        byte_d = shift_q;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CLEANUP: begin
                active_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                active_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= 3'd0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            active_q <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            active_q <= active_d;
            ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q    <= par_d;
            perr_q   <= perr_d;
`endif
        end
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Active    = active_q;
    assign o_Rx_Frame_Err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_Rx_Parity_Err = perr_q;
`else
    // Parity sense has no effect without a parity bit; the output stays low.
    assign o_Rx_Parity_Err = 1'b0 && (PARITY_ODD != 0);
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit with a byte/latency scoreboard.
module tb_uart_rx;

    localparam int CPB = 8;
    localparam int H   = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int EXP_LAT = 3 + H + (FRAME_BITS - 1) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       o_dv;
    logic [7:0] o_byte;
    logic       o_active;
    logic       o_ferr;
    logic       o_perr;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .PARITY_ODD  (0)
    ) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (o_dv),
        .o_Rx_Byte      (o_byte),
        .o_Rx_Active    (o_active),
        .o_Rx_Frame_Err (o_ferr),
        .o_Rx_Parity_Err(o_perr)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q[$];
    int unsigned start_q[$];
    int          n_dv = 0;
    int          n_ferr = 0;
    int          n_perr = 0;
    int unsigned last_dv_cyc = 0;
    int unsigned prev_dv_cyc = 0;
    bit          active_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting at a falling clock edge; good frames are queued.
    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b,
                              input bit good);
        if (good) exp_q.push_back(b);
        start_q.push_back(cyc + 1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_b;
        repeat (CPB) @(negedge clk);
`else
        if (par_b !== 1'bx) rx = 1'b1;
`endif
        rx = stop_b;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_active) active_seen = 1'b1;
            if (o_dv) begin
                n_dv++;
                prev_dv_cyc = last_dv_cyc;
                last_dv_cyc = cyc;
                chk("dv_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("rx_byte", 32'(o_byte), 32'(exp_q.pop_front()));
            end
            if (o_ferr) n_ferr++;
            if (o_perr) n_perr++;
            if (o_ferr || o_perr) chk("no_dv_with_err", 32'(o_dv), 32'd0);
            if (o_dv || o_ferr || o_perr) begin
                chk("frame_pending", 32'(start_q.size() != 0), 32'd1);
                if (start_q.size() != 0) begin
                    int unsigned lat;
                    lat = cyc - start_q.pop_front();
                    chk("latency_window", 32'(lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dv", 32'(o_dv), 32'd0);
        chk("rst_byte", 32'(o_byte), 32'h00);
        chk("rst_active", 32'(o_active), 32'd0);
        chk("rst_ferr", 32'(o_ferr), 32'd0);
        chk("rst_perr", 32'(o_perr), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_active", 32'(o_active), 32'd0);

        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        chk("a5_dv_count", 32'(n_dv), 32'd1);
        chk("a5_ferr_count", 32'(n_ferr), 32'd0);
        chk("a5_byte_hold", 32'(o_byte), 32'hA5);
        chk("a5_active_low", 32'(o_active), 32'd0);

        send_frame(8'h3C, 1'b1, ^8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1, ^8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        chk("b2b_dv_count", 32'(n_dv), 32'd3);
        chk("b2b_spacing", 32'(last_dv_cyc - prev_dv_cyc), 32'(FRAME_BITS * CPB));

        // Abandon 0xFF during data bit 4 with a reset.
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        chk("mid_active", 32'(o_active), 32'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("inrst_dv", 32'(o_dv), 32'd0);
        chk("inrst_byte", 32'(o_byte), 32'h00);
        chk("inrst_active", 32'(o_active), 32'd0);
        chk("inrst_ferr", 32'(o_ferr), 32'd0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        chk("postrst_dv_count", 32'(n_dv), 32'd3);
        send_frame(8'h81, 1'b1, ^8'h81, 1'b1);
        repeat (4) @(negedge clk);
        chk("r81_dv_count", 32'(n_dv), 32'd4);
        chk("r81_byte_hold", 32'(o_byte), 32'h81);

        send_frame(8'h55, 1'b0, ^8'h55, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        chk("ferr_count", 32'(n_ferr), 32'd1);
        chk("ferr_no_dv", 32'(n_dv), 32'd4);
        chk("ferr_byte_kept", 32'(o_byte), 32'h81);

        active_seen = 1'b0;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_no_dv", 32'(n_dv), 32'd4);
        chk("glitch_no_ferr", 32'(n_ferr), 32'd1);
        chk("glitch_no_active", 32'(active_seen), 32'd0);
        send_frame(8'h00, 1'b1, ^8'h00, 1'b1);
        repeat (4) @(negedge clk);
        chk("z00_dv_count", 32'(n_dv), 32'd5);
        chk("z00_byte_hold", 32'(o_byte), 32'h00);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("par_good_dv", 32'(n_dv), 32'd6);
        chk("par_good_no_perr", 32'(n_perr), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("par_bad_perr", 32'(n_perr), 32'd1);
        chk("par_bad_no_dv", 32'(n_dv), 32'd6);
        chk("par_bad_byte_kept", 32'(o_byte), 32'h07);
`else
        chk("no_perr_pulses", 32'(n_perr), 32'd0);
`endif

        repeat (10) @(negedge clk);
        chk("byte_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("frame_queue_drained", 32'(start_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver: 8N1 frames at CLKS_PER_BIT clocks per bit, LSB first.
- Companion to the existing UART transmitter; sits on the same clock and reset at the other end of the serial link.
- Synchronises the asynchronous line and samples each bit at its centre.
- Presents each good byte with a one-cycle valid strobe, and flags framing errors (parity errors when the feature is compiled in).

Parameters:
- CLKS_PER_BIT, 87, system clocks per serial bit (10 MHz / 115200). Legal range 4..255.
- PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- i_Clock  input  1  system clock, all logic on rising edge
- i_Reset  input  1  asynchronous, active-high reset
- i_Rx_Serial  input  1  asynchronous serial line, idle high
- o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a newly received good byte
- o_Rx_Byte  output  8  last good byte; updated only together with o_Rx_DV
- o_Rx_Active  output  1  high while a frame is being received
- o_Rx_Frame_Err  output  1  one-cycle pulse: stop bit sampled low
- o_Rx_Parity_Err  output  1  one-cycle pulse: parity mismatch (constant 0 without the macro)

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0; o_Rx_Byte = 8'h00.
  - Synchroniser flops = 1; state = IDLE; counters = 0.
  - Reset mid-frame abandons the frame with no pulses. After release, the receiver waits for a fresh falling edge.
- Input: 2-flop synchroniser; the state machine sees only the synchronised line (2-cycle delay). The line is sampled only at the centre points defined below.
- Clock counter width is 8 bits. Half-bit point H = (CLKS_PER_BIT-1)/2, integer division.
- IDLE:
  - Counter and bit index = 0.
  - Synchronised line 0 -> START.
- START:
  - Count to H, then sample.
  - Sample 0 -> counter = 0, o_Rx_Active = 1, go to DATA.
  - Sample 1 -> glitch rejected, back to IDLE; no pulses, o_Rx_Active stays 0.
- DATA:
  - Count to CLKS_PER_BIT-1, sample into the shift register at bit index 0..7 (LSB first), counter = 0.
  - After index 7 -> STOP, or PARITY if the feature is enabled.
- STOP:
  - Count to CLKS_PER_BIT-1, sample.
  - Sample 1 -> o_Rx_Byte = shift register and o_Rx_DV = 1, both for that same single cycle; no parity error is allowed in that case.
  - Sample 0 -> o_Rx_Frame_Err = 1 for one cycle; o_Rx_Byte unchanged, no DV.
  - Either way, go to CLEANUP.
- CLEANUP:
  - One cycle; o_Rx_Active = 0; all pulses back to 0; go to IDLE.
- Back-to-back frames: a start bit immediately following the stop bit must be received. Because the stop is sampled at mid-bit, IDLE is re-entered before the next falling edge.
- Latency: o_Rx_DV rises 3 + H + 9*CLKS_PER_BIT cycles (±1) after the first cycle i_Rx_Serial is low at the synchroniser input.
- Break condition (line held low): one framing error, then the line is treated as a new start bit once seen low in IDLE.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8 data bits + 1 parity bit + 1 stop bit.
  - PARITY state: count to CLKS_PER_BIT-1 and sample the parity bit, then go to STOP.
  - Expected parity = XOR of the data bits, inverted when PARITY_ODD = 1.
  - Mismatch -> o_Rx_Parity_Err pulses in the stop-sample cycle; o_Rx_DV is suppressed and o_Rx_Byte is unchanged.
  - Framing error takes the same suppression; both error pulses may assert together.
- Undefined: no PARITY state; o_Rx_Parity_Err tied to 0.

Decomposition:
- Shared package uart_pkg holds:
  - State encodings, 3-bit: IDLE = 0, START = 1, DATA = 2, STOP = 3, CLEANUP = 4, PARITY = 5.
  - Data width constant = 8.
- One sub-module: uart_sync_2ff, a generic 2-flop synchroniser with reset value parameter 1. It is reusable for other asynchronous inputs.

Test Plan:
- All scenarios use CLKS_PER_BIT = 8, driven by the team UART transmitter or a bench model.
- Send 0xA5 -> exactly one o_Rx_DV pulse, o_Rx_Byte = 0xA5, latency within ±1 of 3+3+72 = 78 cycles, o_Rx_Frame_Err = 0.
- Send 0x3C then 0xC3 with no idle gap -> two DV pulses exactly 80 cycles apart, carrying 0x3C then 0xC3.
- Pulse the line low for 2 cycles, then hold it high -> no DV and no error pulse; o_Rx_Active stays 0; a following 0x00 is received correctly.
- Send 0x55 with the stop bit forced to 0 -> one o_Rx_Frame_Err pulse, no DV, o_Rx_Byte still holds the previous value.
- Assert i_Reset during data bit 4 of 0xFF, release it, then send 0x81 -> outputs are 0 during reset; only 0x81 is reported.
- With UART_RX_PARITY_EN and PARITY_ODD = 0:
  - 0x07 with parity bit 1 -> DV with 0x07.
  - 0x07 with parity bit 0 -> o_Rx_Parity_Err pulse, no DV.
